// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single RAM port between an icache (read only) and a
// dcache (read/write). Only one grant is outstanding at a time. The dcache wins
// simultaneous requests. The RAM signals completion by reporting ACCESS on ramstate.
//
// Optional feature, selected by defining MEM_ARBITER_STARVE_GUARD_EN:
//   icache starvation guard. After four back-to-back dcache completions that
//   occurred while the icache was waiting, the next arbitration goes to the icache.
//   With the macro undefined, the dcache has strict priority and no counter exists.
//
// Ports
//   CLK       in   1   rising-edge clock
//   RST       in   1   synchronous active-high reset
//   iREN      in   1   icache read request
//   dREN      in   1   dcache read request
//   dWEN      in   1   dcache write request (a write wins over a read)
//   iaddr     in   32  icache word address
//   daddr     in   32  dcache word address
//   dstore    in   32  dcache write data
//   iwait     out  1   icache stall; low only in the cycle its access completes
//   dwait     out  1   dcache stall; low only in the cycle its access completes
//   iload     out  32  last completed icache read data (registered)
//   dload     out  32  last completed dcache read data (registered)
//   ramREN    out  1   RAM read enable
//   ramWEN    out  1   RAM write enable
//   ramaddr   out  32  RAM address
//   ramstore  out  32  RAM write data
//   ramload   in   32  RAM read data
//   ramstate  in   2   RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   memerr    out  1   sticky RAM error flag, cleared only by reset
module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam logic [1:0] RamFree   = 2'd0;
  localparam logic [1:0] RamBusy   = 2'd1;
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDGrant = 2'd1,
    StIGrant = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        memerr_q;

  logic d_req;
  logic d_done;
  logic i_done;
  logic starve_force;

  assign d_req = dREN | dWEN;

  // A completion needs the owner to still be requesting; a request dropped in the
  // ACCESS cycle is treated as an abort, so no wait pulse and no load update.
  assign d_done = (state_q == StDGrant) && d_req && (ramstate == RamAccess);
  assign i_done = (state_q == StIGrant) && iREN && (ramstate == RamAccess);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  // Consecutive dcache completions seen while the icache was waiting.
  logic [2:0] starve_q;

  assign starve_force = (starve_q == 3'd4) && iREN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= 3'd0;
    end else if (!iREN || i_done) begin
      starve_q <= 3'd0;
    end else if ((state_q == StIdle) && starve_force) begin
      // The forced icache grant consumes the accumulated count.
      starve_q <= 3'd0;
    end else if (d_done && (starve_q != 3'd4)) begin
      starve_q <= starve_q + 3'd1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Arbitration FSM plus the registered load data and error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      iload_q  <= 32'd0;
      dload_q  <= 32'd0;
      memerr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (starve_force) begin
            state_q <= StIGrant;
          end else if (d_req) begin
            state_q <= StDGrant;
          end else if (iREN) begin
            state_q <= StIGrant;
          end
        end

        StDGrant: begin
          if (!d_req) begin
            state_q <= StIdle;
          end else begin
            case (ramstate)
              RamAccess: begin
                // Writes complete without touching the read-data register.
                if (!dWEN) begin
                  dload_q <= ramload;
                end
                state_q <= StIdle;
              end
              RamError: begin
                // Drop the grant; the still-asserted request is re-arbitrated.
                memerr_q <= 1'b1;
                state_q  <= StIdle;
              end
              RamFree, RamBusy: ;
              default: ;
            endcase
          end
        end

        StIGrant: begin
          if (!iREN) begin
            state_q <= StIdle;
          end else begin
            case (ramstate)
              RamAccess: begin
                iload_q <= ramload;
                state_q <= StIdle;
              end
              RamError: begin
                memerr_q <= 1'b1;
                state_q  <= StIdle;
              end
              RamFree, RamBusy: ;
              default: ;
            endcase
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM request side decoded from the current owner. Held quiet while reset is
  // asserted so an abandoned grant never reaches the RAM.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    if (!RST) begin
      unique case (state_q)
        StDGrant: begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
        end
        StIGrant: begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall outputs release combinationally in the completing cycle only.
  assign iwait  = ~(i_done & ~RST);
  assign dwait  = ~(d_done & ~RST);

  assign iload  = iload_q;
  assign dload  = dload_q;
  assign memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] StFree   = 2'd0;
  localparam logic [1:0] StBusy   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StError  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;
  logic        memerr;

  mem_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .iaddr    (iaddr),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_iload = 32'd0;
  logic [31:0] exp_dload = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_grant(input txn_t e, input string tag);
    chk({tag, "_ramaddr"}, ramaddr, e.addr);
    if (e.is_d) begin
      chk({tag, "_ramstore"}, ramstore, e.wdata);
      chk({tag, "_ramWEN"}, {31'd0, ramWEN}, {31'd0, e.wr});
      chk({tag, "_ramREN"}, {31'd0, ramREN}, {31'd0, ~e.wr});
    end else begin
      chk({tag, "_ramstore"}, ramstore, 32'd0);
      chk({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
      chk({tag, "_ramREN"}, {31'd0, ramREN}, 32'd1);
    end
  endtask

  // Called one tick after the edge that granted the front scoreboard entry.
  // Plays the RAM for that access and ends at the falling edge of the IDLE cycle.
  task automatic serve(input string tag, input int busy, input bit keep);
    txn_t e;
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 0; k < busy; k++) begin
      ramstate = (k % 2 == 0) ? StBusy : StFree;
      @(negedge CLK);
      check_grant(e, {tag, "_hold"});
      chk({tag, "_hold_wait"}, {31'd0, e.is_d ? dwait : iwait}, 32'd1);
      next_cycle();
    end
    ramstate = StAccess;
    ramload  = e.rdata;
    @(negedge CLK);
    check_grant(e, {tag, "_acc"});
    chk({tag, "_acc_owner_wait"}, {31'd0, e.is_d ? dwait : iwait}, 32'd0);
    chk({tag, "_acc_other_wait"}, {31'd0, e.is_d ? iwait : dwait}, 32'd1);
    next_cycle();
    ramstate = StFree;
    if (!keep) begin
      if (e.is_d) begin
        dREN = 1'b0;
        dWEN = 1'b0;
      end else begin
        iREN = 1'b0;
      end
    end
    if (e.is_d && !e.wr) exp_dload = e.rdata;
    if (!e.is_d) exp_iload = e.rdata;
    @(negedge CLK);
    chk({tag, "_idle_iload"}, iload, exp_iload);
    chk({tag, "_idle_dload"}, dload, exp_dload);
    chk({tag, "_idle_ramREN"}, {31'd0, ramREN}, 32'd0);
    chk({tag, "_idle_ramWEN"}, {31'd0, ramWEN}, 32'd0);
    chk({tag, "_idle_owner_wait"}, {31'd0, e.is_d ? dwait : iwait}, 32'd1);
  endtask

  initial begin
    // Reset state.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_memerr", {31'd0, memerr}, 32'd0);

    // icache read, two busy cycles before ACCESS.
    iREN = 1'b1; iaddr = 32'h100;
    push(1'b0, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF);
    next_cycle();
    serve("iread", 2, 1'b0);

    // Simultaneous requests: dcache first, then icache.
    iREN = 1'b1; iaddr = 32'h104;
    dREN = 1'b1; daddr = 32'h200;
    push(1'b1, 1'b0, 32'h200, 32'd0, 32'hA5A50001);
    push(1'b0, 1'b0, 32'h104, 32'd0, 32'h0BADF00D);
    next_cycle();
    serve("both_d", 1, 1'b0);
    next_cycle();
    serve("both_i", 0, 1'b0);

    // dcache write with the read bit also set: write wins, dload untouched.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678;
    push(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hFFFF0000);
    next_cycle();
    serve("dwrite", 1, 1'b0);

    // RAM error during a dcache grant: sticky flag, no release, re-grant.
    dREN = 1'b1; daddr = 32'h80; dstore = 32'd0;
    push(1'b1, 1'b0, 32'h80, 32'd0, 32'hCAFEF00D);
    next_cycle();
    ramstate = StError;
    @(negedge CLK);
    chk("err_dwait", {31'd0, dwait}, 32'd1);
    chk("err_ramaddr", ramaddr, 32'h80);
    next_cycle();
    ramstate = StFree;
    @(negedge CLK);
    chk("err_memerr", {31'd0, memerr}, 32'd1);
    chk("err_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("err_dload", dload, exp_dload);
    next_cycle();
    serve("err_retry", 1, 1'b0);
    chk("err_sticky", {31'd0, memerr}, 32'd1);

    // icache drops its request in the ACCESS cycle: abort, no pulse, no load.
    iREN = 1'b1; iaddr = 32'h700;
    next_cycle();
    ramstate = StBusy;
    @(negedge CLK);
    chk("abort_ramREN", {31'd0, ramREN}, 32'd1);
    chk("abort_ramaddr", ramaddr, 32'h700);
    next_cycle();
    iREN = 1'b0; ramstate = StAccess; ramload = 32'h55555555;
    @(negedge CLK);
    chk("abort_iwait", {31'd0, iwait}, 32'd1);
    next_cycle();
    ramstate = StFree;
    @(negedge CLK);
    chk("abort_iload", iload, exp_iload);
    chk("abort_idle_ramREN", {31'd0, ramREN}, 32'd0);

    // Reset in the middle of an icache grant.
    iREN = 1'b1; iaddr = 32'h900;
    next_cycle();
    ramstate = StBusy;
    @(negedge CLK);
    chk("rstmid_ramREN_pre", {31'd0, ramREN}, 32'd1);
    RST = 1'b1; ramstate = StAccess; ramload = 32'h77777777;
    #1;
    chk("rstmid_iwait_during", {31'd0, iwait}, 32'd1);
    chk("rstmid_ramREN_during", {31'd0, ramREN}, 32'd0);
    next_cycle();
    RST = 1'b0; iREN = 1'b0; ramstate = StFree;
    exp_iload = 32'd0; exp_dload = 32'd0;
    @(negedge CLK);
    chk("rstmid_iload", iload, 32'd0);
    chk("rstmid_dload", dload, 32'd0);
    chk("rstmid_iwait", {31'd0, iwait}, 32'd1);
    chk("rstmid_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rstmid_memerr", {31'd0, memerr}, 32'd0);

    // Starvation: dcache held high while the icache waits.
    iREN = 1'b1; iaddr = 32'h500;
    dREN = 1'b1; daddr = 32'h300;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h300, 32'd0, 32'hD0000000 + k);
    push(1'b0, 1'b0, 32'h500, 32'd0, 32'h1CAC4E00);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      serve("starve_d", 1, 1'b1);
    end
    next_cycle();
    serve("starve_i", 1, 1'b0);
`else
    for (int k = 0; k < 6; k++) push(1'b1, 1'b0, 32'h300, 32'd0, 32'hD0000000 + k);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      serve("strict_d", 1, 1'b1);
    end
`endif
    dREN = 1'b0; iREN = 1'b0;
    next_cycle();
    @(negedge CLK);
    chk("end_ramREN", {31'd0, ramREN}, 32'd0);
    chk("end_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
